// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage F/D/E/M/W pipeline: forwarding selects, stalls, flushes.
// Latency: forwarding/stall/flush outputs are combinational; multiply occupies Execute for MUL_LAT cycles.
// Backpressure: a multiply stalls F/D/E and bubbles M; a load-use hazard stalls F/D and bubbles E.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             BranchTakenE,
    input  logic             MulStartE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MulDoneE,
    output logic [CNT_W-1:0] LdStallCnt
);

    localparam int MCW = $clog2(MUL_LAT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

    mul_state_t       state_q, state_d;
    logic [MCW-1:0]   mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;

    logic [1:0] fwd_a, fwd_b;
    logic       mulstall;
    logic       muldone;
    logic       ldrstall;

    // Forwarding selects: Memory-stage result wins over Writeback; R15 is the PC and never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (RegWriteM && (RA1E == WA3M) && (RA1E != 4'd15))
            fwd_a = 2'b10;
        else if (RegWriteW && (RA1E == WA3W) && (RA1E != 4'd15))
            fwd_a = 2'b01;
        if (RegWriteM && (RA2E == WA3M) && (RA2E != 4'd15))
            fwd_b = 2'b10;
        else if (RegWriteW && (RA2E == WA3W) && (RA2E != 4'd15))
            fwd_b = 2'b01;
    end

    // Multiply sequencer: stall for MUL_LAT-1 cycles, then a single done cycle; starts while busy are ignored.
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        mulstall  = 1'b0;
        muldone   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MulStartE) begin
                    mulstall  = 1'b1;
                    mul_cnt_d = MCW'(MUL_LAT - 2);
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (mul_cnt_q != '0) begin
                    mulstall  = 1'b1;
                    mul_cnt_d = mul_cnt_q - MCW'(1);
                end else begin
                    muldone   = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mul_cnt_d = '0;
            end
        endcase
    end

    // Load-use detection (masked by a multiply) and saturating stall-cycle counter.
    always_comb begin
        ldrstall = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E)) && !mulstall;
        ld_cnt_d = ld_cnt_q;
        if (ldrstall && (ld_cnt_q != {CNT_W{1'b1}}))
            ld_cnt_d = ld_cnt_q + CNT_W'(1);
    end

    // State registers with synchronous reset; a reset mid-multiply abandons it without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mul_cnt_q <= '0;
            ld_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            ld_cnt_q  <= ld_cnt_d;
        end
    end

    // Output composition: multiply has priority and masks branch/load-use effects; all outputs quiet in reset.
    always_comb begin
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        MulDoneE   = 1'b0;
        LdStallCnt = '0;
        if (!reset) begin
            ForwardAE  = fwd_a;
            ForwardBE  = fwd_b;
            StallF     = ldrstall | mulstall;
            StallD     = ldrstall | mulstall;
            StallE     = mulstall;
            FlushM     = mulstall;
            FlushD     = BranchTakenE & ~mulstall;
            FlushE     = (ldrstall | BranchTakenE) & ~mulstall;
            MulDoneE   = muldone;
            LdStallCnt = ld_cnt_q;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver pushes model expectations, monitor pops and compares.
// Inputs are applied 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The reference model tracks a multiply by its age in cycles and the counter as a plain integer.
module tb_pipe_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [3:0]       RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic             RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MulStartE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDoneE;
    logic [CNT_W-1:0] LdStallCnt;

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MulDoneE(MulDoneE), .LdStallCnt(LdStallCnt)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwm, rww, m2r, br, mul;
    } stim_t;

    typedef struct packed {
        logic [1:0]       fa, fb;
        logic             sf, sd, se, fd, fe, fm, done;
        logic [CNT_W-1:0] cnt;
    } outs_t;

    outs_t exp_q[$];
    int    checks = 0;
    int    passed = 0;
    int    cycle  = 0;

    // Reference model state: age of the multiply in Execute (-1 = none) and load-use stall count.
    int m_age = -1;
    int m_cnt = 0;

    function automatic logic [1:0] fwd(input logic [3:0] ra, input stim_t s);
        if (ra == 4'd15) return 2'd0;
        if (s.rwm && ra == s.wa3m) return 2'd2;
        if (s.rww && ra == s.wa3w) return 2'd1;
        return 2'd0;
    endfunction

    function automatic outs_t model(input stim_t s);
        outs_t o;
        int    a;
        bit    stall, done, ld;
        o = '0;
        a = (m_age < 0 && s.mul) ? 0 : m_age;
        stall = (a >= 0) && (a < MUL_LAT - 1);
        done  = (a == MUL_LAT - 1);
        ld    = s.m2r && (s.ra1d == s.wa3e || s.ra2d == s.wa3e) && !stall;
        if (s.rst) begin
            m_age = -1;
            m_cnt = 0;
            return o;
        end
        o.fa   = fwd(s.ra1e, s);
        o.fb   = fwd(s.ra2e, s);
        o.sf   = ld || stall;
        o.sd   = ld || stall;
        o.se   = stall;
        o.fm   = stall;
        o.fd   = s.br && !stall;
        o.fe   = (ld || s.br) && !stall;
        o.done = done;
        o.cnt  = CNT_W'(m_cnt);
        if (a < 0 || done) m_age = -1;
        else               m_age = a + 1;
        if (ld && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
        return o;
    endfunction

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        reset        = s.rst;
        RA1D         = s.ra1d;
        RA2D         = s.ra2d;
        RA1E         = s.ra1e;
        RA2E         = s.ra2e;
        WA3E         = s.wa3e;
        WA3M         = s.wa3m;
        WA3W         = s.wa3w;
        RegWriteM    = s.rwm;
        RegWriteW    = s.rww;
        MemtoRegE    = s.m2r;
        BranchTakenE = s.br;
        MulStartE    = s.mul;
        exp_q.push_back(model(s));
    endtask

    function automatic logic [3:0] rnd_reg();
        if ($urandom_range(0, 7) == 0) return 4'd15;
        return 4'($urandom_range(0, 3));
    endfunction

    // Monitor: every falling edge with a pending expectation compares the full output set.
    initial begin
        outs_t e, act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
                       MulDoneE, LdStallCnt};
                checks++;
                if (act === e) passed++;
                else $display("FAIL outputs cycle %0d: got fa=%b fb=%b sf=%b sd=%b se=%b fd=%b fe=%b fm=%b done=%b cnt=%0d, expected fa=%b fb=%b sf=%b sd=%b se=%b fd=%b fe=%b fm=%b done=%b cnt=%0d",
                              cycle, act.fa, act.fb, act.sf, act.sd, act.se, act.fd, act.fe, act.fm, act.done, act.cnt,
                              e.fa, e.fb, e.sf, e.sd, e.se, e.fd, e.fe, e.fm, e.done, e.cnt);
                cycle++;
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        stim_t s;
        reset = 1'b1;
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MulStartE} = '0;

        // Reset with busy-looking inputs: every output must be 0.
        s = '0; s.rst = 1'b1; s.mul = 1'b1; s.br = 1'b1; s.rwm = 1'b1; s.m2r = 1'b1;
        step(s);
        step(s);

        // Forwarding priority on A, mirrored on B.
        s = '0; s.ra1e = 4'd3; s.wa3m = 4'd3; s.wa3w = 4'd3; s.rwm = 1'b1; s.rww = 1'b1;
        s.ra2e = 4'd3; s.wa3e = 4'd9;
        step(s);
        s.rwm = 1'b0;
        step(s);
        s.rwm = 1'b1; s.ra1e = 4'd15; s.ra2e = 4'd15; s.wa3m = 4'd15; s.wa3w = 4'd15;
        step(s);

        // Load-use hazard on RA2D.
        s = '0; s.m2r = 1'b1; s.wa3e = 4'd5; s.ra2d = 4'd5; s.ra1d = 4'd1;
        step(s);
        s.m2r = 1'b0;
        step(s);

        // Taken branch alone.
        s = '0; s.br = 1'b1; s.wa3e = 4'd7;
        step(s);
        // Load-use together with branch.
        s.m2r = 1'b1; s.ra1d = 4'd7;
        step(s);

        // Multiply held high from T, branch at T+1 masked, then done; back-to-back start after.
        s = '0; s.mul = 1'b1; s.wa3e = 4'd2; s.ra1d = 4'd2; s.m2r = 1'b1;
        step(s);
        s.br = 1'b1;
        step(s);
        s.br = 1'b0;
        for (int i = 0; i < MUL_LAT + 2; i++) step(s);
        s = '0;
        step(s);

        // Reset in the middle of a multiply.
        s = '0; s.mul = 1'b1;
        step(s);
        s.rst = 1'b1;
        step(s);
        s = '0;
        step(s);
        step(s);

        // Counter saturation.
        s = '0; s.m2r = 1'b1; s.wa3e = 4'd4; s.ra1d = 4'd4;
        for (int i = 0; i < 20; i++) step(s);
        s = '0; s.rst = 1'b1;
        step(s);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            s.rst  = ($urandom_range(0, 99) == 0);
            s.ra1d = rnd_reg(); s.ra2d = rnd_reg();
            s.ra1e = rnd_reg(); s.ra2e = rnd_reg();
            s.wa3e = rnd_reg(); s.wa3m = rnd_reg(); s.wa3w = rnd_reg();
            s.rwm  = 1'($urandom_range(0, 1));
            s.rww  = 1'($urandom_range(0, 1));
            s.m2r  = ($urandom_range(0, 2) == 0);
            s.br   = ($urandom_range(0, 4) == 0);
            s.mul  = ($urandom_range(0, 3) == 0);
            step(s);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard/sequencing controller for the 5-stage pipeline registers (F/D/E/M/W).
- Drives forwarding selects for Execute and stall/flush enables for the stage registers.
- Handles load-use stalls, taken-branch flushes and a multi-cycle multiply that occupies Execute for MUL_LAT cycles.
- Keeps a saturating load-use stall counter for performance debug.

Parameters:
- MUL_LAT, 4, cycles a multiply instruction occupies Execute; legal range is ≥2.
- CNT_W, 16, width of the load-use stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- RA1D  in  4  source reg 1 of the instruction in Decode
- RA2D  in  4  source reg 2 of the instruction in Decode
- RA1E  in  4  source reg 1 of the instruction in Execute
- RA2E  in  4  source reg 2 of the instruction in Execute
- WA3E  in  4  destination reg, Execute
- WA3M  in  4  destination reg, Memory
- WA3W  in  4  destination reg, Writeback
- RegWriteM  in  1  Memory-stage instruction writes the register file
- RegWriteW  in  1  Writeback-stage instruction writes the register file
- MemtoRegE  in  1  Execute-stage instruction is a load
- BranchTakenE  in  1  taken branch resolved in Execute
- MulStartE  in  1  multiply instruction present in Execute
- ForwardAE  out  2  operand A select: 00 = regfile, 01 = Writeback result, 10 = Memory ALU result
- ForwardBE  out  2  operand B select, same encoding as ForwardAE
- StallF  out  1  hold PC register
- StallD  out  1  hold F/D register
- StallE  out  1  hold D/E register
- FlushD  out  1  clear F/D register
- FlushE  out  1  clear D/E register
- FlushM  out  1  clear E/M register (inserts a bubble)
- MulDoneE  out  1  one-cycle pulse: final Execute cycle of a multiply
- LdStallCnt  out  CNT_W  count of load-use stall cycles

Behaviour:
Reset
- While reset=1, all outputs are driven 0.
- On the reset edge: FSM goes to IDLE, mul counter to 0, LdStallCnt to 0.
- A reset during a multiply aborts it; no MulDoneE pulse is produced.

Forwarding (combinational)
- ForwardAE = 10 if RegWriteM & RA1E==WA3M & RA1E!=15.
- Otherwise ForwardAE = 01 if RegWriteW & RA1E==WA3W & RA1E!=15.
- Otherwise ForwardAE = 00.
- The Memory-stage match has priority over the Writeback-stage match.
- ForwardBE follows the same rules using RA2E.
- R15 (PC) is never forwarded.

Multiply FSM (states IDLE, BUSY; counter width clog2(MUL_LAT))
- IDLE & MulStartE: mulstall=1 in that cycle; counter loads MUL_LAT-2; next state BUSY.
- BUSY & counter!=0: mulstall=1; counter decrements.
- BUSY & counter==0: mulstall=0; MulDoneE=1; next state IDLE.
- Net effect: mulstall is high for exactly MUL_LAT-1 consecutive cycles, and MulDoneE pulses in the following cycle.
- MulStartE seen while BUSY is ignored; it belongs to the same instruction.
- MulStartE in the same cycle as the MulDoneE pulse is also ignored.
- A back-to-back multiply is recognised starting in the next IDLE cycle.

Load-use
- ldrstall = MemtoRegE & (RA1D==WA3E | RA2D==WA3E) & ~mulstall.

Stall/flush composition
- StallF = StallD = ldrstall | mulstall.
- StallE = mulstall.
- FlushM = mulstall.
- FlushD = BranchTakenE & ~mulstall.
- FlushE = (ldrstall | BranchTakenE) & ~mulstall.
- A multiply in Execute always has priority: it is never flushed, and branch/load-use effects are masked while mulstall=1.
- Simultaneous ldrstall and BranchTakenE: StallF/StallD=1, FlushD=1, FlushE=1.

Counter
- LdStallCnt increments by 1 on each clock edge where ldrstall=1 and reset=0.
- It saturates at 2^CNT_W-1 and never wraps.

Test Plan:
- Forwarding priority: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Set RA1E=15 with both writes -> 00.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5, no multiply -> StallF=StallD=FlushE=1, FlushD=0 for one cycle; LdStallCnt 0->1.
- Branch: BranchTakenE=1, no other hazard -> FlushD=FlushE=1, all stalls 0.
- Multiply, MUL_LAT=4: MulStartE held high from cycle T -> StallF/D/E and FlushM =1 in T, T+1, T+2; MulDoneE=1 and stalls 0 in T+3. BranchTakenE=1 in T+1 -> FlushD=FlushE=0.
- Reset mid-multiply: MulStartE at T, reset=1 at T+1 -> outputs 0 during T+1. T+2 (reset=0, MulStartE=0) -> IDLE, no MulDoneE, stalls 0.
- Saturation, CNT_W=4: hold ldrstall condition for 20 cycles -> LdStallCnt reaches 15 and stays at 15.
